// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO into a registered valid/ready stream through a two-entry head/skid buffer.
// Optional transfer counter rd_count_o is built when FIFO_STREAM_READER_COUNT_EN is defined.
`timescale 1ns / 1ps

module fifo_stream_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    output logic              fifo_pop_o,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    input  logic              fifo_empty_i,

    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,

    input  logic              flush_i
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    output logic [15:0]       rd_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q;
    logic              valid_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] skid_q;

    logic              pop;
    logic              xfer;

    // Reset gates the pop so no word leaves the FIFO while the reader cannot capture it.
    assign pop  = !reset && !fifo_empty_i && (state_q != ST_TWO) && !flush_i;
    assign xfer = valid_q && m_ready_i;

    assign fifo_pop_o = pop;
    assign m_valid_o  = valid_q;
    assign m_data_o   = head_q;

    // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (pop) begin
                        head_q  <= fifo_pop_data_i;
                        state_q <= ST_ONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (pop && xfer) begin
                        head_q <= fifo_pop_data_i;
                    end else if (pop) begin
                        skid_q  <= fifo_pop_data_i;
                        state_q <= ST_TWO;
                    end else if (xfer) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // The skid word moves up; a pop is never issued from this state.
                    if (xfer) begin
                        head_q  <= skid_q;
                        state_q <= ST_ONE;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [15:0] rd_count_q;
    logic [15:0] rd_count_d;

    // Counts every accepted word, including one accepted in a flush cycle; wraps naturally.
    always_comb begin
        rd_count_d = rd_count_q;
        if (xfer) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count_o = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a queue models the FIFO, outputs are sampled 1ns after each rising edge.
`timescale 1ns / 1ps

module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_pop_o;
    logic [7:0] fifo_pop_data_i;
    logic       fifo_empty_i;
    logic       m_valid_o;
    logic [7:0] m_data_o;
    logic       m_ready_i;
    logic       flush_i;
`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [15:0] rd_count_o;
`endif

    fifo_stream_reader #(.DATA_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_pop_o      (fifo_pop_o),
        .fifo_pop_data_i (fifo_pop_data_i),
        .fifo_empty_i    (fifo_empty_i),
        .m_valid_o       (m_valid_o),
        .m_data_o        (m_data_o),
        .m_ready_i       (m_ready_i),
        .flush_i         (flush_i)
`ifdef FIFO_STREAM_READER_COUNT_EN
        ,
        .rd_count_o      (rd_count_o)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] out_q[$];
    int         pop_cnt;
    int         pop_empty_viol;
    int         stab_viol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty_i    = (fifo_q.size() == 0);
        fifo_pop_data_i = fifo_empty_i ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: sample pop/transfer before the edge, update the FIFO model after it.
    task automatic cycle();
        logic       p;
        logic       x;
        logic [7:0] d;
        #1;
        p = fifo_pop_o;
        x = m_valid_o && m_ready_i;
        d = m_data_o;
        if (p && fifo_empty_i) pop_empty_viol++;
        @(posedge clk);
        #1;
        if (p) begin
            pop_cnt++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (x) out_q.push_back(d);
        drive_fifo();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        m_ready_i      = 1'b1;
        flush_i        = 1'b0;
        pop_cnt        = 0;
        pop_empty_viol = 0;
        stab_viol      = 0;
        drive_fifo();

        // Reset with data waiting: nothing popped, outputs zero.
        push(8'h11); push(8'h22); push(8'h33);
        #1;
        check("rst_valid", 32'(m_valid_o), 32'h0);
        check("rst_data", 32'(m_data_o), 32'h0);
        check("rst_pop", 32'(fifo_pop_o), 32'h0);
        cycle(); cycle();
        check("rst_no_pops", 32'(pop_cnt), 32'd0);
        check("rst_fifo_kept", 32'(fifo_q.size()), 32'd3);

        // Streaming with ready high: one cycle latency, one word per cycle.
        reset = 1'b0;
        out_q.delete();
        cycle();
        check("s1_valid", 32'(m_valid_o), 32'h1);
        check("s1_data", 32'(m_data_o), 32'h11);
        cycle();
        check("s2_data", 32'(m_data_o), 32'h22);
        cycle();
        check("s3_data", 32'(m_data_o), 32'h33);
        check("s3_pops", 32'(pop_cnt), 32'd3);
        cycle();
        check("s4_valid", 32'(m_valid_o), 32'h0);
        check("s_out_cnt", 32'(out_q.size()), 32'd3);

        // Backpressure: two pops fill head and skid, head held stable.
        m_ready_i = 1'b0;
        pop_cnt   = 0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (4) cycle();
        check("bp_pops", 32'(pop_cnt), 32'd2);
        check("bp_valid", 32'(m_valid_o), 32'h1);
        check("bp_data", 32'(m_data_o), 32'hA1);
        check("bp_pop_off", 32'(fifo_pop_o), 32'h0);
        check("bp_fifo_left", 32'(fifo_q.size()), 32'd1);
        m_ready_i = 1'b1;
        out_q.delete();
        cycle();
        check("bp_r1_data", 32'(m_data_o), 32'hA2);
        cycle();
        check("bp_r2_data", 32'(m_data_o), 32'hA3);
        cycle();
        check("bp_r3_valid", 32'(m_valid_o), 32'h0);
        check("bp_out_cnt", 32'(out_q.size()), 32'd3);
        if (out_q.size() == 3) begin
            check("bp_out0", 32'(out_q[0]), 32'hA1);
            check("bp_out1", 32'(out_q[1]), 32'hA2);
            check("bp_out2", 32'(out_q[2]), 32'hA3);
        end

        // Flush from TWO: outputs drop, no pop in the flush cycle, next word follows.
        m_ready_i = 1'b0;
        push(8'h55); push(8'h66);
        cycle(); cycle();
        check("fl_full_data", 32'(m_data_o), 32'h55);
        push(8'h77);
        flush_i = 1'b1;
        pop_cnt = 0;
        #1;
        check("fl_pop_blocked", 32'(fifo_pop_o), 32'h0);
        cycle();
        flush_i = 1'b0;
        check("fl_valid", 32'(m_valid_o), 32'h0);
        check("fl_no_pop", 32'(pop_cnt), 32'd0);
        m_ready_i = 1'b1;
        out_q.delete();
        cycle();
        check("fl_next_valid", 32'(m_valid_o), 32'h1);
        check("fl_next_data", 32'(m_data_o), 32'h77);
        cycle();
        check("fl_out_cnt", 32'(out_q.size()), 32'd1);
        if (out_q.size() == 1) check("fl_out0", 32'(out_q[0]), 32'h77);

        // Asynchronous reset while in TWO.
        m_ready_i = 1'b0;
        push(8'h88); push(8'h99); push(8'hAA);
        cycle(); cycle();
        check("ar_full_data", 32'(m_data_o), 32'h88);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(m_valid_o), 32'h0);
        check("ar_data", 32'(m_data_o), 32'h0);
        check("ar_pop", 32'(fifo_pop_o), 32'h0);
        pop_cnt = 0;
        cycle(); cycle();
        check("ar_no_pops", 32'(pop_cnt), 32'd0);
        check("ar_fifo_kept", 32'(fifo_q.size()), 32'd1);
        reset = 1'b0;
        cycle();
        check("ar_after_valid", 32'(m_valid_o), 32'h1);
        check("ar_after_data", 32'(m_data_o), 32'hAA);
        m_ready_i = 1'b1;
        cycle(); cycle();
        check("ar_drained", 32'(m_valid_o), 32'h0);

        // Random backpressure over 200 words.
        pop_cnt        = 0;
        pop_empty_viol = 0;
        stab_viol      = 0;
        out_q.delete();
        for (int i = 0; i < 200; i++) push(8'(i));
        for (int cyc = 0; cyc < 3000 && out_q.size() < 200; cyc++) begin
            logic       hv;
            logic [7:0] hd;
            m_ready_i = 1'($urandom_range(0, 1));
            hv = m_valid_o && !m_ready_i;
            hd = m_data_o;
            cycle();
            if (hv && (!m_valid_o || m_data_o !== hd)) stab_viol++;
        end
        check("rnd_out_cnt", 32'(out_q.size()), 32'd200);
        for (int i = 0; i < out_q.size() && i < 200; i++) begin
            check($sformatf("rnd_word%0d", i), 32'(out_q[i]), 32'(i));
        end
        check("rnd_pops", 32'(pop_cnt), 32'd200);
        check("rnd_pop_when_empty", 32'(pop_empty_viol), 32'd0);
        check("rnd_stable_hold", 32'(stab_viol), 32'd0);
        m_ready_i = 1'b1;
        repeat (3) cycle();

`ifdef FIFO_STREAM_READER_COUNT_EN
        // Counter wraps through 0xFFFF after 65537 transfers.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        out_q.delete();
        for (int i = 0; i < 65537; i++) fifo_q.push_back(8'(i));
        drive_fifo();
        for (int cyc = 0; cyc < 70000 && out_q.size() < 65537; cyc++) cycle();
        repeat (2) cycle();
        check("cnt_xfers", 32'(out_q.size()), 32'd65537);
        check("cnt_wrap", 32'(rd_count_o), 32'h0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_W, default 8: width of FIFO pop data and stream data.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fifo_pop_o  output  1  pop strobe to the synchronous FIFO; one word is removed per cycle when high.
REQ-005 fifo_pop_data_i  input  DATA_W  FIFO head word, combinationally valid whenever fifo_empty_i=0.
REQ-006 fifo_empty_i  input  1  FIFO empty flag.
REQ-007 m_valid_o  output  1  stream word valid, registered.
REQ-008 m_data_o  output  DATA_W  stream word, registered.
REQ-009 m_ready_i  input  1  downstream accept; a transfer occurs when m_valid_o=1 and m_ready_i=1.
REQ-010 flush_i  input  1  synchronous discard of all words held in the reader.

Function
REQ-011 The reader SHALL hold at most two words: a head register (drives m_data_o) and a skid register.
REQ-012 State machine SHALL have states EMPTY (0 words), ONE (head valid), TWO (head and skid valid); m_valid_o=1 in ONE and TWO only.
REQ-013 fifo_pop_o SHALL equal (!fifo_empty_i && state!=TWO && !flush_i), combinationally.
REQ-014 A popped word SHALL be captured at the same clock edge as the pop, from fifo_pop_data_i.
REQ-015 Transitions, with pop=fifo_pop_o and xfer=m_valid_o&&m_ready_i: EMPTY+pop->ONE; ONE+pop+!xfer->TWO; ONE+!pop+xfer->EMPTY; ONE+pop+xfer->ONE (head loads popped word); ONE+neither->ONE; TWO+xfer->ONE (head loads skid); TWO+!xfer->TWO.
REQ-016 In EMPTY the popped word SHALL load the head; in ONE with pop and no xfer it SHALL load the skid.
REQ-017 Latency: a word at the FIFO head while in EMPTY SHALL appear on m_valid_o/m_data_o exactly one cycle later.
REQ-018 With m_ready_i held high and FIFO non-empty, throughput SHALL be one word per cycle (steady state ONE).
REQ-019 Words SHALL be delivered in FIFO order with no loss or duplication under any m_ready_i pattern.
REQ-020 m_data_o SHALL remain stable while m_valid_o=1 and m_ready_i=0.
REQ-021 flush_i=1 SHALL force next state EMPTY regardless of m_ready_i or fifo_empty_i, with no pop that cycle; a transfer coincident with flush_i still counts as delivered.
REQ-022 fifo_pop_o SHALL never assert while fifo_empty_i=1.

Reset
REQ-023 reset SHALL asynchronously force state EMPTY, m_valid_o=0, m_data_o=0, skid register=0.
REQ-024 During reset fifo_pop_o SHALL be 0; reset mid-stream SHALL discard held words without popping.
REQ-025 First pop after reset deassertion SHALL occur no earlier than the first rising edge with reset low.

Configuration
REQ-026 Macro FIFO_STREAM_READER_COUNT_EN: when defined, output rd_count_o (16 bits) SHALL count completed transfers, reset to 0, wrap 0xFFFF->0x0000, unaffected by flush_i.
REQ-027 When FIFO_STREAM_READER_COUNT_EN is undefined, rd_count_o and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset, FIFO holds 0x11,0x22,0x33, m_ready_i=1 -> pops in cycles 1-3, m_data_o 0x11,0x22,0x33 in cycles 2-4, m_valid_o low cycle 5.
REQ-029 FIFO holds 0xA1,0xA2,0xA3, m_ready_i=0 -> exactly two pops, state TWO, m_data_o=0xA1 stable; raise m_ready_i -> 0xA1,0xA2,0xA3 consecutively.
REQ-030 Random m_ready_i (50%) over 200 words 0x00..0xC7 -> output sequence identical, fifo_pop_o never high with fifo_empty_i=1.
REQ-031 State TWO holding 0x55,0x66, assert flush_i one cycle -> m_valid_o=0 next cycle, no pop that cycle, next FIFO word 0x77 is next delivered.
REQ-032 Assert reset while in TWO -> m_valid_o=0 and m_data_o=0 immediately, no pop until reset deasserts.
REQ-033 With FIFO_STREAM_READER_COUNT_EN, 65537 transfers -> rd_count_o=0x0001.
